// File: rtl/chip8_pkg.sv
// -----------------------------------------------------------------------------
// chip8_pkg
// Shared constants and elaboration-time helpers for the CHIP-8 timing unit.
//   DELAY_TIMER / SOUND_TIMER : indices of the two architectural timers
//   TIMER_W_DEFAULT           : default countdown timer width
//   calc_div()                : integer clock divisor, 0 when arguments are invalid
//   cnt_width()               : counter width able to hold 0..div-1 (min 1 bit)
// -----------------------------------------------------------------------------
package chip8_pkg;

    localparam int DELAY_TIMER     = 0;
    localparam int SOUND_TIMER     = 1;
    localparam int TIMER_W_DEFAULT = 8;

    // A zero result flags a bad frequency pair; the top turns it into an
    // elaboration error rather than silently building a broken divider.
    function automatic int calc_div(input int num, input int den);
        if (num < 1 || den < 1) begin
            return 0;
        end
        return num / den;
    endfunction

    // A divide-by-one counter still needs one bit so the declaration is legal.
    function automatic int cnt_width(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage : chip8_pkg

// File: rtl/strobe_divider.sv
// -----------------------------------------------------------------------------
// strobe_divider
// Free-running prescaler producing a registered one-cycle strobe every DIV
// cycles. The count freezes (and the strobe stays low) while hold is high, so
// resuming keeps the original phase.
//   fpga_clk : system clock
//   rst_in   : synchronous active-high reset
//   hold     : freeze the count and suppress the strobe
//   strobe   : one-cycle pulse, first high DIV cycles after reset
// -----------------------------------------------------------------------------
module strobe_divider
    import chip8_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic fpga_clk,
    input  logic rst_in,
    input  logic hold,
    output logic strobe
);

    localparam int               CNT_W = cnt_width(DIV);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             strobe_q, strobe_d;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        cnt_d    = cnt_q;
        strobe_d = 1'b0;
        if (!hold) begin
            // Registering the terminal-count compare puts the strobe in the
            // cycle after the counter sits at DIV-1.
            strobe_d = (cnt_q == LAST);
            cnt_d    = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge fpga_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of block order.
        if (rst_in) begin
            cnt_q    <= '0;
            strobe_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            strobe_q <= strobe_d;
        end
    end

    assign strobe = strobe_q;

endmodule : strobe_divider

// File: rtl/chip8_tick_timers.sv
// -----------------------------------------------------------------------------
// chip8_tick_timers
// CHIP-8 timing unit on the single fpga_clk domain: CPU step enable, 60 Hz
// timer tick, NUM_TIMERS countdown timers and a square-wave buzzer gated by
// the sound timer, with pause and single-step support for debug.
//   fpga_clk     : system clock
//   rst_in       : synchronous active-high reset
//   pause        : freezes prescalers and timer decrement (not the tone)
//   step_req     : single-step request level; a rising edge while paused
//                  gives one cpu_step pulse
//   cpu_step     : one-cycle CPU advance strobe
//   timer_tick   : one-cycle TIMER_HZ strobe
//   wr_en        : load wr_data into timer[wr_sel]
//   wr_sel       : timer written (out-of-range ignored)
//   wr_data      : value loaded
//   rd_sel       : timer read (out-of-range reads 0)
//   rd_data      : registered read data, 1-cycle latency
//   timer_active : bit i set while timer i is non-zero
//   buzzer       : TONE_HZ square wave while the sound timer is non-zero
// -----------------------------------------------------------------------------
module chip8_tick_timers
    import chip8_pkg::*;
#(
    parameter int CLK_HZ     = 27000000,
    parameter int CPU_HZ     = 700,
    parameter int TIMER_HZ   = 60,
    parameter int TONE_HZ    = 440,
    parameter int NUM_TIMERS = 2,
    parameter int TIMER_W    = TIMER_W_DEFAULT,
    parameter int SOUND_IDX  = SOUND_TIMER
) (
    input  logic                          fpga_clk,
    input  logic                          rst_in,
    input  logic                          pause,
    input  logic                          step_req,
    output logic                          cpu_step,
    output logic                          timer_tick,
    input  logic                          wr_en,
    input  logic [$clog2(NUM_TIMERS)-1:0] wr_sel,
    input  logic [TIMER_W-1:0]            wr_data,
    input  logic [$clog2(NUM_TIMERS)-1:0] rd_sel,
    output logic [TIMER_W-1:0]            rd_data,
    output logic [NUM_TIMERS-1:0]         timer_active,
    output logic                          buzzer
);

    localparam int CPU_DIV   = calc_div(CLK_HZ, CPU_HZ);
    localparam int TIMER_DIV = calc_div(CLK_HZ, TIMER_HZ);
    localparam int TONE_HALF = calc_div(CLK_HZ, 2 * TONE_HZ);

    if (CPU_DIV < 1 || TIMER_DIV < 1 || TONE_HALF < 1 ||
        NUM_TIMERS < 2 || SOUND_IDX < 0 || SOUND_IDX >= NUM_TIMERS) begin : g_param_check
        $error("chip8_tick_timers: invalid divisor or timer parameters");
    end

    // ---------------------------------------------------------------- strobes
    logic cpu_div_strobe;

    strobe_divider #(.DIV(CPU_DIV)) u_cpu_div (
        .fpga_clk (fpga_clk),
        .rst_in   (rst_in),
        .hold     (pause),
        .strobe   (cpu_div_strobe)
    );

    strobe_divider #(.DIV(TIMER_DIV)) u_timer_div (
        .fpga_clk (fpga_clk),
        .rst_in   (rst_in),
        .hold     (pause),
        .strobe   (timer_tick)
    );

    // Single step: rising edge of step_req, honoured only while paused. The
    // prescaler strobe is already held low during pause, so OR-ing is safe.
    logic step_req_q;
    logic step_pulse_q, step_pulse_d;

    assign step_pulse_d = pause && step_req && !step_req_q;
    assign cpu_step     = cpu_div_strobe | step_pulse_q;

    // ----------------------------------------------------------------- timers
    logic [TIMER_W-1:0] timer_q [NUM_TIMERS];
    logic [TIMER_W-1:0] timer_d [NUM_TIMERS];
    logic [TIMER_W-1:0] rd_data_q, rd_data_d;
    logic               dec_en;

    // A tick that lands in the cycle pause rises is dropped so timers never
    // move while the machine is frozen.
    assign dec_en = timer_tick && !pause;

    always_comb begin
        for (int i = 0; i < NUM_TIMERS; i++) begin
            timer_d[i] = timer_q[i];
            // A write wins over a same-cycle tick and is not decremented.
            if (wr_en && (32'(wr_sel) == i)) begin
                timer_d[i] = wr_data;
            end else if (dec_en && (timer_q[i] != '0)) begin
                timer_d[i] = timer_q[i] - TIMER_W'(1);
            end
        end
    end

    // Reads the pre-edge timer value, so a same-cycle write is not visible.
    assign rd_data_d = (32'(rd_sel) < NUM_TIMERS) ? timer_q[rd_sel] : '0;

    always_comb begin
        timer_active = '0;
        for (int i = 0; i < NUM_TIMERS; i++) begin
            timer_active[i] = (timer_q[i] != '0);
        end
    end

    // ----------------------------------------------------------------- buzzer
    localparam int                TONE_W    = cnt_width(TONE_HALF);
    localparam logic [TONE_W-1:0] TONE_LAST = TONE_W'(TONE_HALF - 1);

    logic [TONE_W-1:0] tone_cnt_q, tone_cnt_d;
    logic              buzz_q, buzz_d;
    logic              sound_on;

    assign sound_on = (timer_q[SOUND_IDX] != '0);

    // Tone runs off the raw clock, not the prescalers, so pause leaves it alone.
    always_comb begin
        tone_cnt_d = '0;
        buzz_d     = 1'b0;
        if (sound_on) begin
            if (tone_cnt_q == TONE_LAST) begin
                tone_cnt_d = '0;
                buzz_d     = !buzz_q;
            end else begin
                tone_cnt_d = tone_cnt_q + TONE_W'(1);
                buzz_d     = buzz_q;
            end
        end
    end

    assign buzzer  = buzz_q;
    assign rd_data = rd_data_q;

    // ------------------------------------------------------------- registers
    always_ff @(posedge fpga_clk) begin
        if (rst_in) begin
            step_req_q   <= 1'b0;
            step_pulse_q <= 1'b0;
            rd_data_q    <= '0;
            tone_cnt_q   <= '0;
            buzz_q       <= 1'b0;
            // NOTE: the timer array is architectural state read by the CPU, so
            // it is reset element by element; a plain scratch memory would not be.
            for (int i = 0; i < NUM_TIMERS; i++) begin
                timer_q[i] <= '0;
            end
        end else begin
            step_req_q   <= step_req;
            step_pulse_q <= step_pulse_d;
            rd_data_q    <= rd_data_d;
            tone_cnt_q   <= tone_cnt_d;
            buzz_q       <= buzz_d;
            for (int i = 0; i < NUM_TIMERS; i++) begin
                timer_q[i] <= timer_d[i];
            end
        end
    end

endmodule : chip8_tick_timers
